// File: rtl/muldiv_pkg.sv
// Shared types and constants for the MULT/DIV sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT = 2'b01,
    OP_DIV  = 2'b10
  } op_t;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_START = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_EXC   = 3'd4;
  localparam state_t S_TOUT  = 3'd5;

  localparam int unsigned MAX_WAIT_DEF = 34;

endpackage

// File: rtl/muldiv_wait_counter.sv
// Saturating WAIT-state cycle counter; term flags count == MAX_WAIT.
module muldiv_wait_counter #(
  parameter int unsigned MAX_WAIT = 34
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, holding at MAX_WAIT.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en && (count != CNT_W'(MAX_WAIT))) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the Mult/Div units and HI/LO writes for the control FSM.
// Optional WAIT timeout enabled by defining MULDIV_TIMEOUT_EN.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEF,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              req_ready,
  output logic              mult_start,
  output logic              div_start,
  input  logic              mult_done,
  input  logic              div_done,
  output logic              hi_lo_sel,
  output logic              hi_we,
  output logic              lo_we,
  output logic              busy,
  output logic              done,
  output logic              div_zero_exc,
  output logic              timeout_err
);

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("muldiv_sequencer: MAX_WAIT must be at least 1");
  end

  state_t state;
  state_t state_nxt;
  op_t    op_q;
  op_t    op_nxt;
  logic   unit_done;
  logic   kill;

`ifdef MULDIV_TIMEOUT_EN
  logic cnt_clr;
  logic cnt_en;
  logic cnt_term;

  muldiv_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_counter (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .term  (cnt_term)
  );
`endif

  // Only the unit that was started may complete the operation.
  assign unit_done = (op_q == OP_MULT) ? mult_done : div_done;

  // Flush or reset squashes any pulse or write in the current cycle.
  assign kill = flush | reset;

  // State and latched-op registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      op_q  <= OP_MULT;
    end else begin
      state <= state_nxt;
      op_q  <= op_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    op_nxt       = op_q;
    req_ready    = 1'b0;
    mult_start   = 1'b0;
    div_start    = 1'b0;
    hi_we        = 1'b0;
    lo_we        = 1'b0;
    done         = 1'b0;
    div_zero_exc = 1'b0;
    timeout_err  = 1'b0;
    busy         = (state != S_IDLE);
    hi_lo_sel    = (state != S_IDLE) && (op_q == OP_MULT);
`ifdef MULDIV_TIMEOUT_EN
    cnt_clr      = 1'b0;
    cnt_en       = 1'b0;
`endif

    case (state)
      S_IDLE: begin
        req_ready = ~flush;
        if (req_valid && !flush) begin
          if (req_op == OP_MULT) begin
            op_nxt    = OP_MULT;
            state_nxt = S_START;
          end else if (req_op == OP_DIV) begin
            op_nxt    = OP_DIV;
            state_nxt = (op_b == '0) ? S_EXC : S_START;
          end
        end
      end
      S_START: begin
        mult_start = (op_q == OP_MULT) && !kill;
        div_start  = (op_q == OP_DIV) && !kill;
`ifdef MULDIV_TIMEOUT_EN
        cnt_clr    = 1'b1;
`endif
        state_nxt  = S_WAIT;
      end
      S_WAIT: begin
        if (unit_done) begin
          state_nxt = S_WRITE;
        end
`ifdef MULDIV_TIMEOUT_EN
        else if (cnt_term) begin
          state_nxt = S_TOUT;
        end else begin
          cnt_en = 1'b1;
        end
`endif
      end
      S_WRITE: begin
        hi_we     = ~kill;
        lo_we     = ~kill;
        done      = ~kill;
        state_nxt = S_IDLE;
      end
      S_EXC: begin
        div_zero_exc = ~kill;
        state_nxt    = S_IDLE;
      end
      S_TOUT: begin
`ifdef MULDIV_TIMEOUT_EN
        timeout_err = ~kill;
`endif
        state_nxt   = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    if (flush) begin
      state_nxt = S_IDLE;
    end
  end

endmodule
